// File: rtl/keypad_scan_enc.sv
// keypad_scan_enc: 4x4 active-low matrix keypad scanner with debounced key
// encoding. One column strobe is driven low at a time. The row lines are
// synchronized and sampled once per column dwell. Presses and releases are
// debounced over DEBOUNCE_SCANS consecutive dwell-end samples.
// Optional feature: define KEYPAD_REPEAT_EN to get an auto-repeat key_valid
// pulse every REPEAT_SCANS dwell ends while a key is held.
module keypad_scan_enc #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam bit ONE_SCAN = (DEBOUNCE_SCANS == 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       sync1_q, rs_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             dwell_end;
  logic             row_single;
  logic             rs_idle;
  logic [1:0]       row_idx;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
  assign rep_inc = rep_q + REP_W'(1);
`endif

  assign dwell_end = (div_q == DIV_W'(SCAN_DIV - 1));
  assign rs_idle   = (rs_q == 4'b1111);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      rs_q    <= '1;
    end else begin
      sync1_q <= row_n;
      rs_q    <= sync1_q;
    end
  end

  // Free-running dwell counter, 0..SCAN_DIV-1 in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (dwell_end) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Encode a single low row to its index; anything else is not a single key.
  always_comb begin
    row_single = 1'b0;
    row_idx    = 2'd0;
    unique case (rs_q)
      4'b1110: begin row_single = 1'b1; row_idx = 2'd0; end
      4'b1101: begin row_single = 1'b1; row_idx = 2'd1; end
      4'b1011: begin row_single = 1'b1; row_idx = 2'd2; end
      4'b0111: begin row_single = 1'b1; row_idx = 2'd3; end
      default: begin row_single = 1'b0; row_idx = 2'd0; end
    endcase
  end

  // Active-low 2-to-4 column strobe decode.
  always_comb begin
    col_n = 4'b1111;
    unique case (col_q)
      2'd0:    col_n = 4'b1110;
      2'd1:    col_n = 4'b1101;
      2'd2:    col_n = 4'b1011;
      default: col_n = 4'b0111;
    endcase
  end

  // Scan/debounce FSM: next state, counters and output registers.
  // With DEBOUNCE_SCANS == 1 the first match accepts directly, so SCAN jumps
  // to HOLD and HOLD jumps to SCAN without visiting DEBOUNCE/RELEASE.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = '0;
`endif
    unique case (state_q)
      SCAN: begin
        if (dwell_end) begin
          if (row_single) begin
            cand_d = {col_q, row_idx};
            if (ONE_SCAN) begin
              state_d = HOLD;
              code_d  = {col_q, row_idx};
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (dwell_end) begin
          if (row_single && (row_idx == cand_q[1:0])) begin
            if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
              state_d = HOLD;
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = SCAN;
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
          end
        end
      end
      HOLD: begin
`ifdef KEYPAD_REPEAT_EN
        rep_d = rep_q;
`endif
        if (dwell_end) begin
          if (rs_idle) begin
`ifdef KEYPAD_REPEAT_EN
            rep_d = '0;
`endif
            if (ONE_SCAN) begin
              state_d = SCAN;
              held_d  = 1'b0;
              col_d   = col_q + 2'd1;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE;
              cnt_d   = CNT_W'(1);
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_inc == REP_W'(REPEAT_SCANS)) begin
              rep_d   = '0;
              valid_d = 1'b1;
            end else begin
              rep_d = rep_inc;
            end
`endif
          end
        end
      end
      RELEASE: begin
        if (dwell_end) begin
          if (rs_idle) begin
            if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
              state_d = SCAN;
              held_d  = 1'b0;
              col_d   = col_q + 2'd1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      col_q   <= '0;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Auto-repeat dwell counter, live only while in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_enc.sv
// Testbench for keypad_scan_enc: a physical keypad model drives the rows from
// the strobed column; a dwell-level reference model predicts the outputs.
module tb_keypad_scan_enc;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int REPEAT_SCANS   = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_scan_enc #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .REPEAT_SCANS(REPEAT_SCANS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row_n(row_n),
    .col_n(col_n),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  // Physical keypad: pressed[c*4+r] shorts column c to row r.
  bit pressed [16];

  always_comb begin
    row_n = 4'b1111;
    for (int c = 0; c < 4; c++)
      if (col_n[c] == 1'b0)
        for (int r = 0; r < 4; r++)
          if (pressed[c*4+r]) row_n[r] = 1'b0;
  end

  // Count cycles with key_valid high, to check pulse width.
  int vcount = 0;
  always @(negedge clk) if (key_valid === 1'b1) vcount++;

  // Reference model state (dwell granularity).
  int m_col, m_cand, m_run, m_rel, m_rep, m_code;
  bit m_held;
  int exp_pulse, prev_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int enc(input logic [3:0] s);
    case (s)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_col = 0; m_cand = -1; m_run = 0; m_rel = 0; m_rep = 0; m_code = 0;
    m_held = 1'b0; exp_pulse = 0; prev_pulse = 0;
  endtask

  task automatic clear_keys();
    for (int i = 0; i < 16; i++) pressed[i] = 1'b0;
  endtask

  // Apply the debounce rules to one dwell-end sample of the current column.
  task automatic model_dwell();
    logic [3:0] s;
    int e;
    s = 4'b1111;
    for (int r = 0; r < 4; r++) if (pressed[m_col*4+r]) s[r] = 1'b0;
    e = enc(s);
    exp_pulse = 0;
    if (!m_held) begin
      if (m_cand < 0) begin
        if (e >= 0) begin m_cand = m_col*4 + e; m_run = 1; end
        else m_col = (m_col + 1) % 4;
      end else if (e == m_cand % 4) begin
        m_run++;
      end else begin
        m_cand = -1; m_col = (m_col + 1) % 4;
      end
      if (m_cand >= 0 && m_run >= DEBOUNCE_SCANS) begin
        m_held = 1'b1; m_code = m_cand; m_cand = -1; exp_pulse = 1; m_rel = 0; m_rep = 0;
      end
    end else if (s == 4'b1111) begin
      m_rel++; m_rep = 0;
      if (m_rel >= DEBOUNCE_SCANS) begin m_held = 1'b0; m_rel = 0; m_col = (m_col + 1) % 4; end
    end else if (m_rel > 0) begin
      m_rel = 0; m_rep = 0;
    end else begin
`ifdef KEYPAD_REPEAT_EN
      m_rep++;
      if (m_rep == REPEAT_SCANS) begin m_rep = 0; exp_pulse = 1; end
`endif
    end
  endtask

  // Advance one dwell (SCAN_DIV clocks) and compare against the model.
  task automatic dwell();
    int base;
    logic [3:0] ec;
    base = vcount;
    repeat (SCAN_DIV) @(posedge clk);
    #1;
    model_dwell();
    ec = 4'b1111;
    ec[m_col] = 1'b0;
    check("col_n", col_n, ec);
    check("key_held", key_held, m_held);
    check("key_code", key_code, m_code);
    check("key_valid", key_valid, exp_pulse);
    check("valid_width", vcount - base, prev_pulse);
    prev_pulse = exp_pulse;
  endtask

  initial begin
    int k, n;
    clear_keys();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col_n", col_n, 4'b1110);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_held", key_held, 1'b0);
    check("rst_key_code", key_code, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle rotation.
    repeat (8) dwell();

    // Key at column 2, row 1 held for 10 dwells, then released.
    pressed[2*4+1] = 1'b1;
    repeat (10) dwell();
    check("held_code", key_code, 4'b1001);
    pressed[2*4+1] = 1'b0;
    repeat (5) dwell();

    // One-dwell bounce.
    pressed[m_col*4+2] = 1'b1;
    dwell();
    pressed[(m_col*4+2) % 16] = 1'b0;
    clear_keys();
    repeat (3) dwell();

    // Two rows low in the same column.
    k = m_col;
    pressed[k*4+0] = 1'b1;
    pressed[k*4+1] = 1'b1;
    repeat (6) dwell();
    clear_keys();
    repeat (2) dwell();

    // Release interrupted by a re-press.
    k = m_col*4 + 3;
    pressed[k] = 1'b1;
    repeat (4) dwell();
    pressed[k] = 1'b0;
    dwell();
    pressed[k] = 1'b1;
    dwell();
    repeat (2) dwell();
    pressed[k] = 1'b0;
    repeat (4) dwell();

    // Randomized key activity.
    repeat (60) begin
      n = $urandom_range(0, 9);
      clear_keys();
      if (n >= 4) pressed[$urandom_range(0, 15)] = 1'b1;
      if (n >= 8) pressed[$urandom_range(0, 15)] = 1'b1;
      repeat ($urandom_range(1, 5)) dwell();
    end
    clear_keys();
    repeat (6) dwell();

    // Asynchronous reset while a key is held.
    pressed[m_col*4+0] = 1'b1;
    repeat (4) dwell();
    check("pre_rst_held", key_held, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_col_n", col_n, 4'b1110);
    check("arst_key_held", key_held, 1'b0);
    check("arst_key_code", key_code, 4'h0);
    check("arst_key_valid", key_valid, 1'b0);
    clear_keys();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) dwell();
    pressed[0*4+2] = 1'b1;
    repeat (6) dwell();
    clear_keys();
    repeat (5) dwell();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
